// File: rtl/isdu.sv
// LC-3 instruction sequencing and decode: Moore FSM driving datapath loads, gates, muxes and SRAM strobes.
// Latency: fetch 6 cycles; ALU/JMP/BR-not-taken 7, BR-taken/JSR 8, LDR/STR 11 cycles until the next fetch.
// Backpressure: none on the datapath side; PAUSE holds in PauseIR1/PauseIR2 until one Continue press/release.
module isdu (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S_18, S_33_1, S_33_2, S_33_3, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_25_1, S_25_2, S_25_3, S_27,
    S_07, S_23, S_16_1, S_16_2, S_16_3,
    PAUSE_IR1, PAUSE_IR2
  } state_t;

  state_t state, next_state;

  // State register; reset drops straight to Halted so write strobes release without a clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= HALTED;
    else       state <= next_state;
  end

  // Next-state decode and per-state control word; everything defaults to inactive.
  always_comb begin
    next_state = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    unique case (state)
      HALTED: if (Run) next_state = S_18;
      S_18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
        next_state = S_33_1;
      end
      S_33_1: begin Mem_OE = 1'b0; MIO_EN = 1'b1; next_state = S_33_2; end
      S_33_2: begin Mem_OE = 1'b0; MIO_EN = 1'b1; next_state = S_33_3; end
      S_33_3: begin Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1; next_state = S_35; end
      S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; next_state = S_32; end
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: next_state = S_01;
          4'b0101: next_state = S_05;
          4'b1001: next_state = S_09;
          4'b0000: next_state = S_00;
          4'b1100: next_state = S_12;
          4'b0100: next_state = S_04;
          4'b0110: next_state = S_06;
          4'b0111: next_state = S_07;
          4'b1101: next_state = PAUSE_IR1;
          default: next_state = S_18;
        endcase
      end
      S_01, S_05, S_09: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1; DRMUX = 1'b0;
        LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state == S_01) ? 2'b00 : (state == S_05) ? 2'b01 : 2'b10;
        next_state = S_18;
      end
      S_00: next_state = BEN ? S_22 : S_18;
      S_22: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00; PCMUX = 2'b10; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; next_state = S_21; end
      S_21: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
        next_state = S_18;
      end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
        next_state = (state == S_06) ? S_25_1 : S_23;
      end
      S_25_1: begin Mem_OE = 1'b0; MIO_EN = 1'b1; next_state = S_25_2; end
      S_25_2: begin Mem_OE = 1'b0; MIO_EN = 1'b1; next_state = S_25_3; end
      S_25_3: begin Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1; next_state = S_27; end
      S_27: begin
        GateMDR = 1'b1; DRMUX = 1'b0; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_18;
      end
      S_23: begin
        SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; MIO_EN = 1'b0; LD_MDR = 1'b1;
        next_state = S_16_1;
      end
      S_16_1: begin Mem_WE = 1'b0; next_state = S_16_2; end
      S_16_2: begin Mem_WE = 1'b0; next_state = S_16_3; end
      S_16_3: begin Mem_WE = 1'b0; next_state = S_18; end
      PAUSE_IR1: begin LD_LED = 1'b1; if (Continue) next_state = PAUSE_IR2; end
      PAUSE_IR2: begin LD_LED = 1'b1; if (!Continue) next_state = S_18; end
      default: next_state = HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// Bench for isdu: reset/halt behaviour, per-instruction signature table, randomized
// instruction stream against a control-word sequence model, and PAUSE/reset corner cases.
module tb_isdu;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

  isdu dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mio_en, mem_oe, mem_we;
  } ctl_t;

  ctl_t obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

  int errors = 0;
  int checks = 0;

  task automatic chk_ctl(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: control word actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: control words per instruction step ----------------
  function automatic ctl_t w_idle();
    ctl_t c = '0;
    c.mem_oe = 1'b1; c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_fetch_pc();
    ctl_t c = w_idle();
    c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_read(input bit last);
    ctl_t c = w_idle();
    c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = last;
    return c;
  endfunction

  function automatic ctl_t w_write();
    ctl_t c = w_idle();
    c.mem_we = 1'b0;
    return c;
  endfunction

  function automatic ctl_t w_pc_add(input logic a1, input logic [1:0] a2);
    ctl_t c = w_idle();
    c.addr1mux = a1; c.addr2mux = a2; c.pcmux = 2'b10; c.ld_pc = 1'b1; c.sr1mux = a1;
    return c;
  endfunction

  ctl_t exp_q[$];

  task automatic build_exp(input logic [3:0] op, input logic ir5, input logic ben);
    ctl_t c;
    exp_q.delete();
    exp_q.push_back(w_fetch_pc());
    exp_q.push_back(w_read(1'b0));
    exp_q.push_back(w_read(1'b0));
    exp_q.push_back(w_read(1'b1));
    c = w_idle(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1; exp_q.push_back(c);
    c = w_idle(); c.ld_ben = 1'b1; exp_q.push_back(c);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = w_idle(); c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
        exp_q.push_back(c);
      end
      4'b0000: begin
        exp_q.push_back(w_idle());
        if (ben) exp_q.push_back(w_pc_add(1'b0, 2'b10));
      end
      4'b1100: exp_q.push_back(w_pc_add(1'b1, 2'b00));
      4'b0100: begin
        c = w_idle(); c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; exp_q.push_back(c);
        exp_q.push_back(w_pc_add(1'b0, 2'b11));
      end
      4'b0110, 4'b0111: begin
        c = w_idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1; exp_q.push_back(c);
        if (op == 4'b0110) begin
          exp_q.push_back(w_read(1'b0));
          exp_q.push_back(w_read(1'b0));
          exp_q.push_back(w_read(1'b1));
          c = w_idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; exp_q.push_back(c);
        end else begin
          c = w_idle(); c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; exp_q.push_back(c);
          repeat (3) exp_q.push_back(w_write());
        end
      end
      default: ;
    endcase
  endtask

  // Entered at a negedge while the DUT sits in the fetch-start state; leaves at the next one.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic ir5, input logic ben);
    Opcode = op; IR_5 = ir5; BEN = ben;
    build_exp(op, ir5, ben);
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge Clk);
      chk_ctl($sformatf("%s op=%b step%0d", tag, op, i), obs, exp_q[i]);
    end
    @(negedge Clk);
  endtask

  // Observes one instruction and tallies its signature until fetch restarts (bounded).
  task automatic measure_instr(input logic [3:0] op, input logic ir5, input logic ben,
                               output int len, output int n_reg, output int n_pc,
                               output int n_we, output int n_oe, output int n_both);
    Opcode = op; IR_5 = ir5; BEN = ben;
    len = 0; n_reg = 0; n_pc = 0; n_we = 0; n_oe = 0; n_both = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0 && GatePC && LD_MAR) break;
      len++;
      n_reg += int'(LD_REG); n_pc += int'(LD_PC);
      n_we += int'(!Mem_WE); n_oe += int'(!Mem_OE); n_both += int'(!Mem_WE && !Mem_OE);
      @(negedge Clk);
    end
  endtask

  typedef struct {
    logic [3:0] op; logic ir5; logic ben;
    int len; int n_reg; int n_pc; int n_we; int n_oe;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int len, n_reg, n_pc, n_we, n_oe, n_both;
    logic [3:0] op;
    ctl_t w;

    vecs = '{
      '{4'b0001, 1'b1, 1'b0,  7, 1, 1, 0, 3},
      '{4'b0101, 1'b0, 1'b0,  7, 1, 1, 0, 3},
      '{4'b1001, 1'b1, 1'b1,  7, 1, 1, 0, 3},
      '{4'b0000, 1'b0, 1'b0,  7, 0, 1, 0, 3},
      '{4'b0000, 1'b0, 1'b1,  8, 0, 2, 0, 3},
      '{4'b1100, 1'b0, 1'b0,  7, 0, 2, 0, 3},
      '{4'b0100, 1'b0, 1'b0,  8, 1, 2, 0, 3},
      '{4'b0110, 1'b0, 1'b0, 11, 1, 1, 0, 6},
      '{4'b0111, 1'b0, 1'b0, 11, 0, 1, 3, 3},
      '{4'b1111, 1'b1, 1'b1,  6, 0, 1, 0, 3},
      '{4'b0010, 1'b0, 1'b0,  6, 0, 1, 0, 3}
    };

    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0; IR_5 = 1'b0; BEN = 1'b0;
    @(negedge Clk);
    chk_ctl("reset_state", obs, w_idle());
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk_ctl("halted_no_run", obs, w_idle());

    // Run pulse, then ADD R1,R1,#1 (0x1261: IR[5]=1) checked cycle by cycle.
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    run_instr("add_1261", 4'b0001, 1'b1, 1'b0);
    chk_ctl("add_back_to_fetch", obs, w_fetch_pc());

    // Per-instruction signature table.
    foreach (vecs[i]) begin
      measure_instr(vecs[i].op, vecs[i].ir5, vecs[i].ben, len, n_reg, n_pc, n_we, n_oe, n_both);
      chk_int($sformatf("len op=%b ben=%b", vecs[i].op, vecs[i].ben), len, vecs[i].len);
      chk_int($sformatf("ld_reg op=%b", vecs[i].op), n_reg, vecs[i].n_reg);
      chk_int($sformatf("ld_pc op=%b ben=%b", vecs[i].op, vecs[i].ben), n_pc, vecs[i].n_pc);
      chk_int($sformatf("we_low op=%b", vecs[i].op), n_we, vecs[i].n_we);
      chk_int($sformatf("oe_low op=%b", vecs[i].op), n_oe, vecs[i].n_oe);
      chk_int($sformatf("oe_we_overlap op=%b", vecs[i].op), n_both, 0);
    end

    // Randomized instruction stream; Run/Continue toggle randomly and must be ignored.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'b1101) op = 4'b1110;
      Run = 1'($urandom); Continue = 1'($urandom);
      run_instr("rand", op, 1'($urandom), 1'($urandom));
    end
    Run = 1'b0; Continue = 1'b0;

    // PAUSE: held in PauseIR1 while Continue low, one press/release returns to fetch.
    run_instr("pause_fetch", 4'b1101, 1'b0, 1'b0);
    w = w_idle(); w.ld_led = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_ctl($sformatf("pause1_hold%0d", k), obs, w);
      @(negedge Clk);
    end
    Continue = 1'b1;
    @(negedge Clk);
    chk_ctl("pause2_enter", obs, w);
    @(negedge Clk);
    chk_ctl("pause2_hold", obs, w);
    Continue = 1'b0;
    @(negedge Clk);
    chk_ctl("pause_exit_fetch", obs, w_fetch_pc());

    // Reset in the middle of a write: strobes release before the next edge.
    Opcode = 4'b0111; IR_5 = 1'b0; BEN = 1'b0;
    repeat (9) @(negedge Clk);
    chk_ctl("str_in_write", obs, w_write());
    Reset = 1'b1;
    #1;
    chk_ctl("reset_mid_write_async", obs, w_idle());
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk_ctl("halted_after_reset", obs, w_idle());

    // Restart and run one more STR end to end after the abort.
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    run_instr("str_after_reset", 4'b0111, 1'b0, 1'b0);
    chk_ctl("str_back_to_fetch", obs, w_fetch_pc());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
